pipe_elastic_buffer: RTL and testbench

//   Parametrised elastic pipeline buffer; successor to the single-register stall/flush stage.

---
 rtl/pipe_elastic_buffer.sv | 114 +++++++++++
 tb/tb_pipe_elastic_buffer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_elastic_buffer.sv
// Purpose : elastic valid/ready buffer with a DEPTH-entry circular store between two pipeline stages.
// Latency : 1 cycle from accepted input to out_data; never combinational fall-through.
// Backpr. : in_ready depends only on held state and flush (no path from out_ready); full stalls input.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous assert, active-low reset
//   flush      synchronous discard of all held entries (wins over a push)
//   in_valid   producer has data          in_ready   buffer can accept
//   in_data    producer payload
//   out_valid  buffer holds data          out_ready  consumer takes data
//   out_data   head entry (0 while empty when ZERO_ON_EMPTY)
//   occupancy  entries held, 0..DEPTH
//
// Parameters
//   WIDTH          payload width
//   DEPTH          entry count; must be a power of two and at least 2
//   ZERO_ON_EMPTY  1: out_data forced to 0 while empty, 0: head slot shown as-is

module pipe_elastic_buffer #(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 2,
    parameter bit ZERO_ON_EMPTY = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     occupancy
);

    // AW addresses the store; pointers carry one extra wrap bit so that
    // full and empty are distinguishable without a separate counter.
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;
    logic [WIDTH-1:0] w_head;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];

    // Same slot index: equal wrap bits means empty, opposite means full.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // in_ready is built from the pointers and flush only, so a full buffer
    // refuses input even when the consumer drains it in the same cycle; the
    // freed slot becomes visible one cycle later.
    assign in_ready  = ~w_full & ~flush;
    assign out_valid = ~w_empty;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // Pointer difference modulo 2*DEPTH is the fill level, 0..DEPTH.
    assign occupancy = r_wr_ptr - r_rd_ptr;

    assign w_head = r_mem[w_rd_idx];

    generate
        if (ZERO_ON_EMPTY) begin : g_zero_empty
            assign out_data = w_empty ? '0 : w_head;
        end else begin : g_stale_empty
            assign out_data = w_head;
        end
    endgenerate

    // Pointer state. Flush returns both pointers to zero; a pop in the
    // flush cycle still completes for the consumer because the head is
    // simply dropped along with everything else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage. Cleared on reset so out_data reads 0 out of reset even when
    // the empty masking is disabled. w_push is already false during flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[w_wr_idx] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_elastic_buffer.sv
module tb_pipe_elastic_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    // DEPTH=2 instance
    logic        fl2, iv2, ordy2, ir2, ov2;
    logic [31:0] d2, od2;
    logic [1:0]  occ2;

    // DEPTH=4 instance
    logic        fl4, iv4, ordy4, ir4, ov4;
    logic [31:0] d4, od4;
    logic [2:0]  occ4;

    pipe_elastic_buffer #(.WIDTH(32), .DEPTH(2), .ZERO_ON_EMPTY(1'b1)) dut2 (
        .clk(clk), .reset(reset), .flush(fl2),
        .in_valid(iv2), .in_ready(ir2), .in_data(d2),
        .out_valid(ov2), .out_ready(ordy2), .out_data(od2),
        .occupancy(occ2)
    );

    pipe_elastic_buffer #(.WIDTH(32), .DEPTH(4), .ZERO_ON_EMPTY(1'b1)) dut4 (
        .clk(clk), .reset(reset), .flush(fl4),
        .in_valid(iv4), .in_ready(ir4), .in_data(d4),
        .out_valid(ov4), .out_ready(ordy4), .out_data(od4),
        .occupancy(occ4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic fl, input logic iv, input logic [31:0] d, input logic ordy,
                       input logic e_ir, input logic e_ov, input logic [31:0] e_od, input logic [1:0] e_occ);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
        tbl.push_back(v);
    endtask

    logic [31:0] q[$];
    int pushed, popped, wr_cnt;
    bit do_push, do_pop, drained;

    initial begin
        reset = 1'b0;
        fl2 = 0; iv2 = 0; ordy2 = 0; d2 = '0;
        fl4 = 0; iv4 = 0; ordy4 = 0; d4 = '0;

        // Outputs under reset
        #12;
        chk("rst in_ready", {31'b0, ir2}, 32'd1);
        chk("rst out_valid", {31'b0, ov2}, 32'd0);
        chk("rst out_data", od2, 32'd0);
        chk("rst occupancy", {30'b0, occ2}, 32'd0);
        chk("rst4 occupancy", {29'b0, occ4}, 32'd0);
        @(negedge clk) reset = 1'b1;

        // Vector columns: flush, in_valid, in_data, out_ready | in_ready, out_valid, out_data, occupancy
        // Fill with consumer stalled: only A0, A1 accepted.
        add(0, 1, 32'hA0, 0,   1, 0, 32'h00, 0);
        add(0, 1, 32'hA1, 0,   1, 1, 32'hA0, 1);
        add(0, 1, 32'hA2, 0,   0, 1, 32'hA0, 2);
        add(0, 1, 32'hA3, 0,   0, 1, 32'hA0, 2);
        // Full with out_ready=1: pop A0, no push this cycle.
        add(0, 1, 32'hB0, 1,   0, 1, 32'hA0, 2);
        // Freed slot usable now; push 0x77 to refill.
        add(0, 1, 32'h77, 0,   1, 1, 32'hA1, 1);
        // Flush at occupancy 2 with 0x55 offered.
        add(1, 1, 32'h55, 0,   0, 1, 32'hA1, 2);
        add(0, 0, 32'h55, 0,   1, 0, 32'h00, 0);
        // Streaming 0x10..0x19.
        add(0, 1, 32'h10, 1,   1, 0, 32'h00, 0);
        for (int k = 1; k < 10; k++)
            add(0, 1, 32'h10 + k, 1,   1, 1, 32'h10 + k - 1, 1);
        add(0, 0, 32'h00, 1,   1, 1, 32'h19, 1);
        add(0, 0, 32'h00, 0,   1, 0, 32'h00, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            fl2 = tbl[i].fl; iv2 = tbl[i].iv; d2 = tbl[i].d; ordy2 = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d in_ready", i),  {31'b0, ir2},  {31'b0, tbl[i].e_ir});
            chk($sformatf("vec%0d out_valid", i), {31'b0, ov2},  {31'b0, tbl[i].e_ov});
            chk($sformatf("vec%0d out_data", i),  od2,           tbl[i].e_od);
            chk($sformatf("vec%0d occupancy", i), {30'b0, occ2}, {30'b0, tbl[i].e_occ});
        end

        // Flush while the consumer pops the head: head is not re-presented.
        @(negedge clk) iv2 = 1; d2 = 32'hC0; ordy2 = 0;
        @(negedge clk) d2 = 32'hC1;
        @(negedge clk) d2 = 32'hCC; fl2 = 1; ordy2 = 1;
        #1;
        chk("flushpop in_ready", {31'b0, ir2}, 32'd0);
        chk("flushpop head", od2, 32'hC0);
        @(negedge clk) fl2 = 0; ordy2 = 0; d2 = 32'hC2;
        #1;
        chk("postflush out_valid", {31'b0, ov2}, 32'd0);
        chk("postflush occupancy", {30'b0, occ2}, 32'd0);
        @(negedge clk) iv2 = 0;
        #1;
        chk("postflush new head", od2, 32'hC2);
        chk("postflush occ1", {30'b0, occ2}, 32'd1);
        @(negedge clk) ordy2 = 1;
        @(negedge clk) ordy2 = 0;
        #1;
        chk("drain empty", {31'b0, ov2}, 32'd0);

        // DEPTH=4: nine pushes with random consumer stalls, queue scoreboard.
        pushed = 0; popped = 0; wr_cnt = 0; drained = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            iv4   = (pushed < 9);
            d4    = 32'h40 + pushed;
            ordy4 = (cyc >= 12) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            chk("d4 occupancy", {29'b0, occ4}, q.size());
            chk("d4 out_valid", {31'b0, ov4}, (q.size() != 0) ? 32'd1 : 32'd0);
            chk("d4 in_ready", {31'b0, ir4}, (q.size() < 4) ? 32'd1 : 32'd0);
            chk("d4 wrap bit", {31'b0, dut4.r_wr_ptr[2]}, (wr_cnt >> 2) & 1);
            if (q.size() != 0) chk("d4 head order", od4, q[0]);
            else chk("d4 empty data", od4, 32'd0);
            do_push = iv4 && (q.size() < 4);
            do_pop  = ordy4 && (q.size() != 0);
            if (do_pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (do_push) begin
                q.push_back(d4);
                pushed++;
                wr_cnt = (wr_cnt + 1) % 8;
            end
            if (popped == 9 && pushed == 9) begin
                drained = 1;
                break;
            end
        end
        chk("d4 drained in budget", {31'b0, drained}, 32'd1);
        chk("d4 pop count", popped, 32'd9);
        @(negedge clk) iv4 = 0; ordy4 = 0;
        #1;
        chk("d4 final empty", {29'b0, occ4}, 32'd0);

        // Asynchronous reset between edges with data held.
        @(negedge clk) iv2 = 1; d2 = 32'hD0; ordy2 = 0;
        @(negedge clk) d2 = 32'hD1;
        @(negedge clk) iv2 = 0;
        #1;
        chk("prereset occupancy", {30'b0, occ2}, 32'd2);
        #1 reset = 1'b0;
        #1;
        chk("async rst out_valid", {31'b0, ov2}, 32'd0);
        chk("async rst occupancy", {30'b0, occ2}, 32'd0);
        chk("async rst in_ready", {31'b0, ir2}, 32'd1);
        chk("async rst out_data", od2, 32'd0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        #1;
        chk("after rst still empty", {31'b0, ov2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
